// File: rtl/st_calc_seq_if.sv
// Link between the run sequencer and one 4x4 state calculator; x11 sits in [8:0], row-major.
// Master is the sequencer (drives start and state in), slave is the calculator.
interface st_calc_seq_if;
  logic         calc_start;
  logic         calc_done;
  logic [8:0]   calc_lambda;
  logic [143:0] calc_x;
  logic [143:0] xin;

  modport master (output calc_start, xin, input calc_done, calc_lambda, calc_x);
  modport slave  (input calc_start, xin, output calc_done, calc_lambda, calc_x);
endinterface

// File: rtl/st_calc_seq.sv
// Sequences one Monte Carlo Hawkes run: per step launch calculator, wait for fresh done, capture and feed back.
// Step latency is calc latency + 3 cycles; new starts are ignored while busy, WAIT aborts after TIMEOUT cycles.
module st_calc_seq #(
  parameter int NUM_STEPS = 16,
  parameter int TIMEOUT   = 64,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [8:0]    s_cfg,
  input  logic [1:0]    k_cfg,
  input  logic [8:0]    rnd,
  output logic          rnd_req,
  output logic          busy,
  output logic          done,
  output logic          err,
  st_calc_seq_if.master calc,
  output logic [8:0]    s,
  output logic [1:0]    k,
  output logic [8:0]    lambda_last,
  output logic [8:0]    lambda_max,
  output logic [CW-1:0] step_cnt,
  output logic [CW-1:0] ev_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(NUM_STEPS - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, FINISH} state_t;

  state_t       state, state_nxt;
  logic [TW-1:0] tmo;
  logic         armed;
  logic         calc_start_c;
  logic [143:0] xin_q;

  assign calc.calc_start = calc_start_c;
  assign calc.xin        = xin_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    calc_start_c = 1'b0;
    rnd_req      = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = LAUNCH;
      LAUNCH: begin
        calc_start_c = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (armed && calc.calc_done) state_nxt = CAPTURE;
        else if (tmo == TMO_LAST)    state_nxt = FINISH;
      end
      CAPTURE: begin
        rnd_req   = 1'b1;
        state_nxt = (step_cnt == LAST_STEP) ? FINISH : LAUNCH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      err         <= 1'b0;
      s           <= '0;
      k           <= '0;
      xin_q       <= '0;
      lambda_last <= '0;
      lambda_max  <= '0;
      step_cnt    <= '0;
      ev_cnt      <= '0;
      tmo         <= '0;
      armed       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          s           <= s_cfg;
          k           <= k_cfg;
          xin_q       <= '0;
          lambda_last <= '0;
          lambda_max  <= '0;
          step_cnt    <= '0;
          ev_cnt      <= '0;
          err         <= 1'b0;
          busy        <= 1'b1;
        end
        LAUNCH: begin
          tmo   <= '0;
          armed <= 1'b0;
        end
        WAIT: begin
          // a done left high from the previous step must drop once before it counts
          if (!calc.calc_done) armed <= 1'b1;
          if (!(armed && calc.calc_done)) begin
            if (tmo == TMO_LAST) err <= 1'b1;
            else                 tmo <= tmo + TW'(1);
          end
        end
        CAPTURE: begin
          xin_q       <= calc.calc_x;
          lambda_last <= calc.calc_lambda;
          if (calc.calc_lambda > lambda_max) lambda_max <= calc.calc_lambda;
          if ((rnd < calc.calc_lambda) && (ev_cnt != CNT_MAX)) ev_cnt <= ev_cnt + CW'(1);
          if (step_cnt != CNT_MAX) step_cnt <= step_cnt + CW'(1);
        end
        FINISH: busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
